writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage; sole driver of the register-file write port (WA, write_data, write_enable).
//  Takes completed results from the MEM stage over a valid/ready handshake.
//  Queues them in a DEPTH-entry FIFO and commits them one per cycle as registered single-cycle write pulses.
//  Honours a port-hold from the hazard unit and offers a forwarding lookup over all uncommitted results.
// PARAMETERS
//  DATA_W  32  result / register width
//  ADDR_W  5   register index width (2**ADDR_W registers, index 0 hard-wired zero)
//  DEPTH   2   FIFO entries (power of two, >=2)
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous, active-high reset
//  in_valid      in   1       MEM stage presents a result
//  in_ready      out  1       stage can accept; transfer when in_valid&in_ready at posedge
//  in_rd         in   ADDR_W  destination register
//  in_data       in   DATA_W  result value
//  in_reg_write  in   1       result must be written back
//  flush         in   1       synchronous discard of all uncommitted entries
//  wb_hold       in   1       register-file port unavailable this cycle; no pop
//  WA            out  ADDR_W  register-file write address
//  write_data    out  DATA_W  register-file write data
//  write_enable  out  1       one-cycle write strobe
//  fwd_qa        in   ADDR_W  forwarding query register
//  fwd_hit       out  1       uncommitted or committing write to fwd_qa exists
//  fwd_qdata     out  DATA_W  youngest such value (0 when !fwd_hit)
//  retire_count  out  16      number of register writes committed
// BEHAVIOUR
//  Reset (async, rst=1): FIFO empty; write_enable=0, WA=0, write_data=0, retire_count=0; in_ready=1 once released.
//  in_ready = (count < DEPTH) & !flush; depends only on registered state and flush, never on in_valid or wb_hold.
//  Accept: in_valid & in_ready at posedge.
//   - Enqueue only if in_reg_write=1 and in_rd!=0.
//   - Otherwise the transfer completes and the result is dropped (no write, no count).
//  Pop: at posedge, if FIFO non-empty (pre-edge state) and !wb_hold and !flush, the head moves to WA/write_data.
//   - write_enable=1 for exactly that following cycle.
//   - Otherwise write_enable=0.
//  WA/write_data are registered and hold their last committed value while write_enable=0; they change only at a pop edge.
//  Latency: accepted at edge N, empty FIFO, no hold -> write_enable high in cycle after edge N+1; 1 commit/cycle sustained.
//  Full (count=DEPTH): in_ready=0 even if a pop occurs the same edge (no same-cycle bypass).
//  Simultaneous push+pop at count<DEPTH: both occur; count unchanged; order preserved.
//  wb_hold: FIFO contents frozen except pushes; a pulse already driven completes; the head waits.
//  Flush: at posedge with flush=1, FIFO cleared and write_enable=0 next cycle.
//   - Any in_valid that cycle is not accepted.
//   - The write already strobing during the flush cycle is considered committed.
//  retire_count: +1 at every posedge where write_enable=1; wraps 16'hFFFF -> 0.
//  Forwarding (combinational): search output register (while write_enable=1) plus all FIFO entries.
//   - Youngest entry matching fwd_qa wins; fwd_qa=0 always gives fwd_hit=0.
//  rst asserted mid-operation: pending entries lost, outputs to reset values immediately.
// TESTING
//  1 Single write r5=32'hA5A5_0001 into empty stage -> write_enable pulse 1 cycle, 2 edges after accept; WA=5; retire_count=1.
//  2 Back-to-back r1=1, r2=2, r3=3, r4=4 with wb_hold=0 -> 4 consecutive pulses in order; in_ready never drops.
//  3 wb_hold=1 for 5 cycles while pushing r1..r3 -> in_ready=0 after 2 accepts.
//    Release -> r1 then r2 strobed, then r3 accepted; no loss, no duplicate.
//  4 Push rd=0 data=FFFF_FFFF and rd=7 with in_reg_write=0 -> both accepted; no write_enable; retire_count unchanged.
//  5 Queue r6=10 then r6=20 with hold=1, fwd_qa=6 -> fwd_hit=1, fwd_qdata=20.
//    Flush -> fwd_hit=0, no writes, in_ready=1.
//  6 rst pulsed asynchronously between edges with FIFO full -> outputs zero without clock; retire_count=0; next accept works.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage and sole driver of the register-file write port.
//   Results arrive from the MEM stage over a valid/ready handshake, are queued
//   in a DEPTH-entry FIFO and committed one per cycle as registered,
//   single-cycle write pulses. A hazard-unit hold freezes commits, a flush
//   discards everything uncommitted, and a combinational forwarding lookup
//   covers every uncommitted or committing result.
//
// Ports
//   clk, rst                     rising-edge clock, async active-high reset
//   in_valid/in_ready            MEM-stage handshake
//   in_rd/in_data/in_reg_write   destination, value, write-back request
//   flush                        discard all uncommitted entries
//   wb_hold                      register-file port busy, no commit
//   WA/write_data/write_enable   register-file write port (registered)
//   fwd_qa/fwd_hit/fwd_qdata     forwarding query and youngest match
//   retire_count                 committed-write counter (wraps)
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              wb_hold,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  input  logic [ADDR_W-1:0] fwd_qa,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_qdata,
  output logic [15:0]       retire_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic              r_we;
  logic [15:0]       r_retire;

  logic              w_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // Readiness looks only at registered occupancy and flush, so a pop on the
  // same edge never frees a slot early.
  assign w_ready  = (r_count < C_DEPTH) & ~flush;
  assign w_accept = in_valid & w_ready;
  // Results with no write-back or targeting r0 complete the handshake but
  // are dropped.
  assign w_push   = w_accept & in_reg_write & (in_rd != ADDR_W'(0));
  assign w_pop    = (r_count != (PTR_W+1)'(0)) & ~wb_hold & ~flush;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= (PTR_W+1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_rd[i]   <= ADDR_W'(0);
        r_mem_data[i] <= DATA_W'(0);
      end
    end else if (flush) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= (PTR_W+1)'(0);
    end else begin
      if (w_push) begin
        r_mem_rd[r_wr_ptr]   <= in_rd;
        r_mem_data[r_wr_ptr] <= in_data;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Register-file write port: address/data only change on a commit edge,
  // the strobe lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wa <= ADDR_W'(0);
      r_wd <= DATA_W'(0);
      r_we <= 1'b0;
    end else if (w_pop) begin
      r_wa <= r_mem_rd[r_rd_ptr];
      r_wd <= r_mem_data[r_rd_ptr];
      r_we <= 1'b1;
    end else begin
      r_we <= 1'b0;
    end
  end

  // Committed-write counter; a strobe live during a flush still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire <= 16'd0;
    end else if (r_we) begin
      r_retire <= r_retire + 16'd1;
    end else begin
      r_retire <= r_retire;
    end
  end

  // Forwarding search from oldest (the strobing output) to youngest FIFO
  // entry so the last match overwrites earlier ones.
  always_comb begin : fwd_search
    logic [PTR_W-1:0] v_idx;
    w_fwd_hit  = 1'b0;
    w_fwd_data = DATA_W'(0);
    v_idx      = r_rd_ptr;
    if (r_we && (r_wa == fwd_qa)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_wd;
    end else begin
      w_fwd_hit  = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < r_count) && (r_mem_rd[v_idx] == fwd_qa)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_mem_data[v_idx];
      end else begin
        w_fwd_hit  = w_fwd_hit;
      end
    end
    // r0 is hard-wired zero and is never forwarded.
    if (fwd_qa == ADDR_W'(0)) begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = DATA_W'(0);
    end else begin
      w_fwd_hit  = w_fwd_hit;
    end
  end

  assign in_ready     = w_ready;
  assign WA           = r_wa;
  assign write_data   = r_wd;
  assign write_enable = r_we;
  assign retire_count = r_retire;
  assign fwd_hit      = w_fwd_hit;
  assign fwd_qdata    = w_fwd_data;

endmodule
